// File: rtl/config_pkg.sv
// Shared types and constants for the configuration chain loader.
// Holds default sizing, loader states and the CRC-16-CCITT constants.
package config_pkg;

    localparam int BITSTREAM_LEN_DEFAULT = 4416;
    localparam int WORD_W_DEFAULT        = 32;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_CHECK
    } ld_state_t;

endpackage

// File: rtl/config_crc16.sv
// Serial CRC-16-CCITT, one bit per clock, MSB-first polynomial form.
// clear reloads the init value; bit_valid qualifies bit_in.
module config_crc16
    import config_pkg::*;
(
    input  logic        prog_clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [15:0] crc
);

    logic fb;

    assign fb = crc[15] ^ bit_in;

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (bit_valid) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Word-stream to serial config-chain loader (LSB-first, one bit per prog_clk).
// Optional trailer CRC check is built in when CONFIG_LOADER_CRC_EN is defined.
module config_loader
    import config_pkg::*;
#(
    parameter int BITSTREAM_LEN = BITSTREAM_LEN_DEFAULT,
    parameter int WORD_W        = WORD_W_DEFAULT
) (
    input  logic                                 prog_clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [WORD_W-1:0]                    s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic                                 prog_in,
    output logic                                 prog_en,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [$clog2(BITSTREAM_LEN+1)-1:0]   bit_count
);

    localparam int CNT_W     = $clog2(BITSTREAM_LEN + 1);
    localparam int NWORDS    = (BITSTREAM_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = BITSTREAM_LEN - (NWORDS - 1) * WORD_W;
    localparam int WC_W      = $clog2(NWORDS + 1);
    localparam int SC_W      = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(BITSTREAM_LEN);
    localparam logic [WC_W-1:0]  NW_C     = WC_W'(NWORDS);
    localparam logic [WC_W-1:0]  NW_LAST  = WC_W'(NWORDS - 1);
    localparam logic [SC_W-1:0]  FULL_B   = SC_W'(WORD_W);
    localparam logic [SC_W-1:0]  LAST_B   = SC_W'(LAST_BITS);

`ifdef CONFIG_LOADER_CRC_EN
    localparam ld_state_t DRAIN_NXT = ST_CHECK;
`else
    localparam ld_state_t DRAIN_NXT = ST_IDLE;
`endif

    ld_state_t         state, state_nxt;
    logic [WC_W-1:0]   words_acc;
    logic [WORD_W-1:0] sh_data;
    logic [SC_W-1:0]   sh_cnt;
    logic [WORD_W-1:0] buf_data;
    logic [SC_W-1:0]   buf_bits;
    logic              buf_full;
    logic              done_q;
    logic              err_q;

    logic go, kill, shifting, all_acc, all_out, accept;
    logic issue_sh, issue_buf, issue, issue_bit;

    assign go        = (state == ST_IDLE) && start;
    assign kill      = (state != ST_IDLE) && abort;
    assign shifting  = (state == ST_STREAM) || (state == ST_DRAIN);
    assign all_acc   = (words_acc == NW_C);
    assign all_out   = (bit_count == LEN_C);
    assign accept    = s_valid && s_ready;
    // the buffer refills the shifter in the same cycle it runs dry
    assign issue_sh  = shifting && !abort && (sh_cnt != '0);
    assign issue_buf = shifting && !abort && (sh_cnt == '0) && buf_full;
    assign issue     = issue_sh || issue_buf;
    assign issue_bit = issue_sh ? sh_data[0] : buf_data[0];

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start)   state_nxt = ST_STREAM;
            ST_STREAM: if (all_acc) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (all_out) state_nxt = DRAIN_NXT;
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK:  if (accept)  state_nxt = ST_IDLE;
`endif
            default:                state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_comb begin
        s_ready = (state == ST_STREAM) && !buf_full && !all_acc;
`ifdef CONFIG_LOADER_CRC_EN
        if (state == ST_CHECK) s_ready = 1'b1;
`endif
        busy = (state != ST_IDLE);
        done = done_q;
        err  = err_q;
    end

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc;
    logic        crc_ok;

    config_crc16 u_crc (
        .prog_clk  (prog_clk),
        .rst       (rst),
        .clear     (go),
        .bit_in    (issue_bit),
        .bit_valid (issue),
        .crc       (crc)
    );

    assign crc_ok = (s_data[15:0] == crc);
`endif

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            words_acc <= '0;
            sh_data   <= '0;
            sh_cnt    <= '0;
            buf_data  <= '0;
            buf_bits  <= '0;
            buf_full  <= 1'b0;
            prog_in   <= 1'b0;
            prog_en   <= 1'b0;
            bit_count <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (go) begin
                err_q     <= 1'b0;
                bit_count <= '0;
                words_acc <= '0;
                buf_full  <= 1'b0;
                sh_cnt    <= '0;
                prog_en   <= 1'b0;
            end else if (kill) begin
                prog_en  <= 1'b0;
                buf_full <= 1'b0;
                sh_cnt   <= '0;
            end else begin
                prog_en <= issue;
                if (issue) begin
                    prog_in   <= issue_bit;
                    bit_count <= bit_count + 1'b1;
                end
                if (issue_sh) begin
                    sh_data <= sh_data >> 1;
                    sh_cnt  <= sh_cnt - 1'b1;
                end else if (issue_buf) begin
                    sh_data <= buf_data >> 1;
                    sh_cnt  <= buf_bits - 1'b1;
                end
                if (accept && state == ST_STREAM) begin
                    buf_data  <= s_data;
                    buf_bits  <= (words_acc == NW_LAST) ? LAST_B : FULL_B;
                    buf_full  <= 1'b1;
                    words_acc <= words_acc + 1'b1;
                end else if (issue_buf) begin
                    buf_full <= 1'b0;
                end
`ifdef CONFIG_LOADER_CRC_EN
                if (accept && state == ST_CHECK) begin
                    done_q <= crc_ok;
                    err_q  <= err_q | !crc_ok;
                end
`else
                if (state == ST_DRAIN && all_out) done_q <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: full, throttled, partial, abort, reset.
// Also exercises the trailer CRC path when CONFIG_LOADER_CRC_EN is defined.
module tb_config_loader;

    localparam int LEN_A = 4416;
    localparam int LEN_B = 100;
    localparam int W     = 32;

    logic        prog_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] s_data;
    logic        s_valid;
    logic        sel;

    logic        a_rdy, a_pi, a_pe, a_busy, a_done, a_err;
    logic [12:0] a_bc;
    logic        b_rdy, b_pi, b_pe, b_busy, b_done, b_err;
    logic [6:0]  b_bc;

    logic        rdy, pi, pe, busy, dn, err;
    logic [12:0] bc;

    always #5 prog_clk = ~prog_clk;

    config_loader #(.BITSTREAM_LEN(LEN_A), .WORD_W(W)) dut_a (
        .prog_clk  (prog_clk),
        .rst       (rst),
        .start     (start & ~sel),
        .abort     (abort & ~sel),
        .s_data    (s_data),
        .s_valid   (s_valid & ~sel),
        .s_ready   (a_rdy),
        .prog_in   (a_pi),
        .prog_en   (a_pe),
        .busy      (a_busy),
        .done      (a_done),
        .err       (a_err),
        .bit_count (a_bc)
    );

    config_loader #(.BITSTREAM_LEN(LEN_B), .WORD_W(W)) dut_b (
        .prog_clk  (prog_clk),
        .rst       (rst),
        .start     (start & sel),
        .abort     (abort & sel),
        .s_data    (s_data),
        .s_valid   (s_valid & sel),
        .s_ready   (b_rdy),
        .prog_in   (b_pi),
        .prog_en   (b_pe),
        .busy      (b_busy),
        .done      (b_done),
        .err       (b_err),
        .bit_count (b_bc)
    );

    assign rdy  = sel ? b_rdy  : a_rdy;
    assign pi   = sel ? b_pi   : a_pi;
    assign pe   = sel ? b_pe   : a_pe;
    assign busy = sel ? b_busy : a_busy;
    assign dn   = sel ? b_done : a_done;
    assign err  = sel ? b_err  : a_err;
    assign bc   = sel ? {6'b0, b_bc} : a_bc;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   first_en = 0;
    int   last_en = 0;
    int   exp_done = 0;
    logic exp_q[$];
    logic [15:0] crc_m;

    task automatic chk_b(input string n, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", n, act, exp);
    endtask

    task automatic chk_i(input string n, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic fail(input string n);
        checks++;
        $display("FAIL %s: event seen, required none", n);
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // scoreboard monitor: every enabled bit must match the queue head
    always @(negedge prog_clk) begin
        cyc++;
        if (pe) begin
            if (en_cnt == 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
            if (exp_q.size() == 0) fail("extra_prog_bit");
            else chk_b("prog_bit", pi, exp_q.pop_front());
        end
        if (dn) begin
            if (exp_done == 0) begin
                fail("unexpected_done");
            end else begin
                exp_done--;
                chk_i("done_en_cnt", en_cnt, sel ? LEN_B : LEN_A);
                chk_i("done_bit_count", int'(bc), sel ? LEN_B : LEN_A);
                chk_b("done_busy_low", busy, 1'b0);
`ifndef CONFIG_LOADER_CRC_EN
                chk_i("done_after_last_bit", last_en, cyc - 1);
`endif
            end
        end
    end

    task automatic do_start();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        en_cnt = 0;
        crc_m = 16'hFFFF;
    endtask

    task automatic hs(input logic [31:0] w, input bit thr, output int acc_c);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        acc_c = 0;
        while (!acc && t < 2000) begin
            s_data  = w;
            s_valid = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge prog_clk); #1;
            acc   = s_valid && rdy;
            acc_c = cyc;
            @(posedge prog_clk); #1;
            t++;
        end
        s_valid = 1'b0;
        if (!acc) fail("handshake_timeout");
    endtask

    task automatic push_word(input logic [31:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(w[i]);
            crc_m = crc_upd(crc_m, w[i]);
        end
    endtask

    task automatic load(input int nw, input int len, input bit thr, input bit good);
        int acc0, ac, nb, t;
        logic [31:0] w;
        acc0 = 0;
        do_start();
        chk_b("busy_after_start", busy, 1'b1);
        chk_b("err_clear_after_start", err, 1'b0);
        if (good) exp_done++;
        for (int k = 0; k < nw; k++) begin
            w  = $urandom;
            nb = (len - W * k > W) ? W : len - W * k;
            push_word(w, nb);
            hs(w, thr, ac);
            if (k == 0) acc0 = ac;
        end
`ifdef CONFIG_LOADER_CRC_EN
        hs({16'h0, good ? crc_m : crc_m ^ 16'h0001}, thr, ac);
`endif
        t = 0;
        do begin
            @(negedge prog_clk); #1;
            t++;
        end while (busy && t < 20000);
        if (busy) fail("done_timeout");
        @(negedge prog_clk); #1;
        chk_i("first_bit_latency", first_en, acc0 + 2);
        if (!thr) chk_i("gapless_run", last_en - first_en + 1, len);
        chk_i("exp_q_drained", exp_q.size(), 0);
        chk_i("done_pulses_seen", exp_done, 0);
        chk_b("err_final", err, !good);
        chk_b("s_ready_idle", rdy, 1'b0);
        chk_b("prog_en_idle", pe, 1'b0);
    endtask

    task automatic start_bg_load();
        do_start();
        fork
            begin
                int ac;
                logic [31:0] w;
                for (int k = 0; k < LEN_A / W; k++) begin
                    w = $urandom;
                    push_word(w, W);
                    hs(w, 1'b0, ac);
                end
            end
        join_none
    endtask

    task automatic wait_bits(input int n);
        int t;
        t = 0;
        do begin
            @(negedge prog_clk); #1;
            t++;
        end while (int'(bc) != n && t < 20000);
        if (int'(bc) != n) chk_i("wait_bit_count", int'(bc), n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        s_data = '0; s_valid = 1'b0; sel = 1'b0;
        crc_m = 16'hFFFF;
        @(negedge prog_clk); #1;
        chk_b("rst_s_ready", a_rdy, 1'b0);
        chk_b("rst_prog_in", a_pi, 1'b0);
        chk_b("rst_prog_en", a_pe, 1'b0);
        chk_b("rst_busy", a_busy, 1'b0);
        chk_b("rst_done", a_done, 1'b0);
        chk_b("rst_err", a_err, 1'b0);
        chk_i("rst_bit_count", int'(a_bc), 0);
        @(posedge prog_clk); #1;
        rst = 1'b0;

        load(LEN_A / W, LEN_A, 1'b0, 1'b1);
        load(LEN_A / W, LEN_A, 1'b1, 1'b1);

        start_bg_load();
        wait_bits(1000);
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        disable fork;
        s_valid = 1'b0;
        @(negedge prog_clk); #1;
        chk_b("abort_prog_en", pe, 1'b0);
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_s_ready", rdy, 1'b0);
        chk_b("abort_done", dn, 1'b0);
        chk_b("abort_err", err, 1'b0);
        exp_q.delete();
        load(LEN_A / W, LEN_A, 1'b0, 1'b1);

        start_bg_load();
        wait_bits(2000);
        #1 rst = 1'b1;
        #1;
        chk_b("arst_s_ready", a_rdy, 1'b0);
        chk_b("arst_prog_in", a_pi, 1'b0);
        chk_b("arst_prog_en", a_pe, 1'b0);
        chk_b("arst_busy", a_busy, 1'b0);
        chk_b("arst_done", a_done, 1'b0);
        chk_b("arst_err", a_err, 1'b0);
        chk_i("arst_bit_count", int'(a_bc), 0);
        disable fork;
        s_valid = 1'b0;
        exp_q.delete();
        @(posedge prog_clk); #1;
        rst = 1'b0;
        load(LEN_A / W, LEN_A, 1'b0, 1'b1);

        sel = 1'b1;
        load(4, LEN_B, 1'b0, 1'b1);
`ifdef CONFIG_LOADER_CRC_EN
        load(4, LEN_B, 1'b0, 1'b0);
        load(4, LEN_B, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
